uart_tx_queue: RTL and testbench

//  Transmit byte queue sitting between the UART CSR write path and uart_transceiver.

---
 rtl/uart_tx_queue.sv | 95 +++++++++
 tb/tb_uart_tx_queue.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: CSR-fed byte FIFO that launches one UART frame at a time
// and pulses drained_irq when the last queued byte has gone out.
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [7:0]          wr_data,
    input  logic                wr_en,
    input  logic                flush,
    input  logic                clr_ovf,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] level,
    output logic                overflow,
    output logic [7:0]          tx_data,
    output logic                tx_wr,
    input  logic                tx_done,
    output logic                busy,
    output logic                drained_irq
);
    localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    logic                    full_q, empty_q, ovf_q, ovf_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_wr_q, tx_wr_d, irq_q, irq_d;
    logic                    push, launch;
    logic [7:0]              mem [2**DEPTH_LOG2];

    always_comb begin
        push      = wr_en && level_q != DEPTH && !flush;
        launch    = state_q == IDLE && level_q != '0 && !flush;
        level_d   = flush ? '0 : level_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(launch);
        wr_ptr_d  = wr_ptr_q + DEPTH_LOG2'(push);
        rd_ptr_d  = flush ? wr_ptr_q : rd_ptr_q + DEPTH_LOG2'(launch);
        // A full-push is dropped even if a launch frees a slot in the same cycle.
        ovf_d     = (wr_en && level_q == DEPTH) || (ovf_q && !clr_ovf);
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        irq_d     = 1'b0;
        if (launch) begin
            state_d   = WAIT;
            tx_wr_d   = 1'b1;
            tx_data_d = mem[rd_ptr_q];
        end else if (state_q == WAIT && tx_done) begin
            state_d = IDLE;
            irq_d   = level_d == '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            tx_data_q <= 8'h00;
            tx_wr_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            full_q    <= level_d == DEPTH;
            empty_q   <= level_d == '0;
            ovf_q     <= ovf_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            irq_q     <= irq_d;
        end
    end

    assign full        = full_q;
    assign empty       = empty_q;
    assign level       = level_q;
    assign overflow    = ovf_q;
    assign tx_data     = tx_data_q;
    assign tx_wr       = tx_wr_q;
    assign busy        = state_q == WAIT;
    assign drained_irq = irq_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed scenarios plus random traffic against a queue-based
// reference model; launched bytes are scoreboarded and all outputs compared every cycle.
module tb_uart_tx_queue;
    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          wr_en = 1'b0, flush = 1'b0, clr_ovf = 1'b0, tx_done = 1'b0;
    logic          full, empty, overflow, tx_wr, busy, drained_irq;
    logic [DL:0]   level;
    logic [7:0]    tx_data;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    uart_tx_queue #(.DEPTH_LOG2(DL)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
        .flush(flush), .clr_ovf(clr_ovf), .full(full), .empty(empty), .level(level),
        .overflow(overflow), .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done),
        .busy(busy), .drained_irq(drained_irq)
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue plus an "in flight" flag.
    logic [7:0] q[$];
    logic [7:0] exp_tx[$];
    bit         m_busy, m_ovf, m_irq, m_txwr;
    logic [7:0] m_txdata;

    always @(posedge clk) begin
        bit launch, drop;
        if (!rst_n) begin
            q.delete();
            exp_tx.delete();
            m_busy = 0; m_ovf = 0; m_irq = 0; m_txwr = 0; m_txdata = 8'h00;
        end else begin
            launch = !m_busy && q.size() != 0 && !flush;
            drop   = wr_en && q.size() == DEPTH;
            m_irq  = 0;
            m_txwr = 0;
            if (flush) q.delete();
            else begin
                if (launch) begin
                    m_txdata = q.pop_front();
                    exp_tx.push_back(m_txdata);
                    m_txwr = 1;
                end
                if (wr_en && !drop) q.push_back(wr_data);
            end
            m_ovf = drop || (m_ovf && !clr_ovf);
            if (launch) m_busy = 1;
            else if (m_busy && tx_done) begin
                m_busy = 0;
                m_irq  = q.size() == 0;
            end
        end
    end

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("level", int'(level), q.size());
            chk("full", int'(full), int'(q.size() == DEPTH));
            chk("empty", int'(empty), int'(q.size() == 0));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("busy", int'(busy), int'(m_busy));
            chk("drained_irq", int'(drained_irq), int'(m_irq));
            chk("tx_wr", int'(tx_wr), int'(m_txwr));
            chk("tx_data", int'(tx_data), int'(m_txdata));
            if (tx_wr) begin
                if (exp_tx.size() == 0) chk("sb_unexpected_launch", 1, 0);
                else chk("sb_launch_byte", int'(tx_data), int'(exp_tx.pop_front()));
            end
        end
    end

    task automatic step(input bit we = 0, input logic [7:0] d = 8'h00, input bit fl = 0,
                        input bit co = 0, input bit td = 0);
        wr_en = we; wr_data = d; flush = fl; clr_ovf = co; tx_done = td;
        @(negedge clk); #1;
    endtask

    initial begin
        @(negedge clk); #1 chk_en = 1'b1;
        @(negedge clk); #1 rst_n = 1'b1;
        // single byte
        step(1, 8'h41);
        repeat (4) step();
        step(0, 0, 0, 0, 1);
        repeat (3) step();
        // five bytes, slow acks
        for (int i = 1; i <= 5; i++) step(1, 8'(i));
        for (int k = 0; k < 5; k++) begin
            repeat (20) step();
            step(0, 0, 0, 0, 1);
        end
        repeat (3) step();
        // overflow, clear, drain with wrap
        for (int i = 0; i < 18; i++) step(1, 8'(8'h80 + i));
        step(0, 0, 0, 1);
        step();
        for (int k = 0; k < 17; k++) begin
            repeat (3) step();
            step(0, 0, 0, 0, 1);
        end
        repeat (3) step();
        // full-push coinciding with a launch
        for (int i = 0; i < 17; i++) step(1, 8'(8'hc0 + i));
        step(0, 0, 0, 0, 1);
        step(1, 8'hee);
        step(0, 0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0, 0, 1);
        repeat (3) step();
        // flush with a frame in flight
        for (int i = 0; i < 7; i++) step(1, 8'(8'h20 + i));
        step();
        step(0, 0, 1);
        repeat (3) step();
        step(0, 0, 0, 0, 1);
        repeat (3) step();
        // reset mid-frame, then a stray tx_done
        for (int i = 0; i < 4; i++) step(1, 8'(8'h50 + i));
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2) step();
        step(0, 0, 0, 0, 1);
        repeat (3) step();
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 49) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0);
        end
        rst_n = 1'b1;
        for (int n = 0; n < 2 * DEPTH + 8; n++) step(0, 0, 0, 0, n % 2 == 1);
        repeat (3) step();
        chk("sb_leftover", exp_tx.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
